// File: rtl/pulse_seq_pkg.sv
// Shared types for the two-pulse sequence generator: FSM states, timing-field width and config record.
package pulse_seq_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] width;
    logic [CNT_W_DEF-1:0] delay;
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] blank;
  } cfg_t;

endpackage

// File: rtl/pulse_seq_cfg.sv
// Shadow/active timing registers with validity check; pending shadow moves to active on the apply strobe.
// PULSE_SEQ_RECV_GATE_EN adds the blank field to the stored config and to the validity rule.
module pulse_seq_cfg
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIDTH_DEF  = 30,
  parameter int unsigned DELAY_DEF  = 200,
  parameter int unsigned PERIOD_DEF = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
`ifdef PULSE_SEQ_RECV_GATE_EN
  input  logic [CNT_W-1:0] cfg_blank,
  output logic [CNT_W-1:0] act_blank,
`endif
  input  logic             apply,
  output logic             cfg_err,
  output logic [CNT_W-1:0] act_width,
  output logic [CNT_W-1:0] act_delay,
  output logic [CNT_W-1:0] act_period
);

  localparam int unsigned EW = CNT_W + 3;

  logic [EW-1:0]    need;
  logic             valid;
  logic             pending;
  logic [CNT_W-1:0] sh_width;
  logic [CNT_W-1:0] sh_delay;
  logic [CNT_W-1:0] sh_period;
`ifdef PULSE_SEQ_RECV_GATE_EN
  logic [CNT_W-1:0] sh_blank;
`endif

  // 3W+D(+blank)+1 evaluated wide so no combination of field values can wrap
  always_comb begin
    need = {3'b000, cfg_width} + {2'b00, cfg_width, 1'b0} + {3'b000, cfg_delay} + EW'(1);
`ifdef PULSE_SEQ_RECV_GATE_EN
    need = need + {3'b000, cfg_blank};
`endif
    valid = (cfg_width != '0) && (need <= {3'b000, cfg_period});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_width   <= CNT_W'(WIDTH_DEF);
      sh_delay   <= CNT_W'(DELAY_DEF);
      sh_period  <= CNT_W'(PERIOD_DEF);
      act_width  <= CNT_W'(WIDTH_DEF);
      act_delay  <= CNT_W'(DELAY_DEF);
      act_period <= CNT_W'(PERIOD_DEF);
`ifdef PULSE_SEQ_RECV_GATE_EN
      sh_blank   <= '0;
      act_blank  <= '0;
`endif
      pending    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !valid;
      // A load landing on an apply cycle refills the shadow after the old value moves to active
      if (apply && pending) begin
        act_width  <= sh_width;
        act_delay  <= sh_delay;
        act_period <= sh_period;
`ifdef PULSE_SEQ_RECV_GATE_EN
        act_blank  <= sh_blank;
`endif
      end
      if (cfg_load && valid) begin
        sh_width  <= cfg_width;
        sh_delay  <= cfg_delay;
        sh_period <= cfg_period;
`ifdef PULSE_SEQ_RECV_GATE_EN
        sh_blank  <= cfg_blank;
`endif
        pending   <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulse_seq_gen.sv
// Two-pulse (W, gap D, 2W) sequence generator repeating every P cycles, all outputs registered.
// PULSE_SEQ_RECV_GATE_EN enables the cfg_blank port and the recv_gate window; otherwise recv_gate is 0.
module pulse_seq_gen
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIDTH_DEF  = 30,
  parameter int unsigned DELAY_DEF  = 200,
  parameter int unsigned PERIOD_DEF = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             single,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_period,
`ifdef PULSE_SEQ_RECV_GATE_EN
  input  logic [CNT_W-1:0] cfg_blank,
`endif
  output logic             pulse_out,
  output logic             sync,
  output logic             busy,
  output logic             cfg_err,
  output logic             recv_gate
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             single_q;
  logic             counting;
  logic             at_end;
  logic             apply;
  logic             in_pulse;
  logic [CNT_W-1:0] act_width, act_delay, act_period;
  logic [CNT_W-1:0] p2_start, p2_end;
`ifdef PULSE_SEQ_RECV_GATE_EN
  logic [CNT_W-1:0] act_blank;
`endif

  pulse_seq_cfg #(
    .CNT_W     (CNT_W),
    .WIDTH_DEF (WIDTH_DEF),
    .DELAY_DEF (DELAY_DEF),
    .PERIOD_DEF(PERIOD_DEF)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_width (cfg_width),
    .cfg_delay (cfg_delay),
    .cfg_period(cfg_period),
`ifdef PULSE_SEQ_RECV_GATE_EN
    .cfg_blank (cfg_blank),
    .act_blank (act_blank),
`endif
    .apply     (apply),
    .cfg_err   (cfg_err),
    .act_width (act_width),
    .act_delay (act_delay),
    .act_period(act_period)
  );

  assign counting = (state != IDLE);
  assign at_end   = counting && (cnt == act_period - CNT_W'(1));
  assign apply    = !counting || at_end;
  assign p2_start = act_width + act_delay;
  assign p2_end   = p2_start + act_width + act_width;
  assign in_pulse = (cnt < act_width) || ((cnt >= p2_start) && (cnt < p2_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      single_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (counting && (cnt == '0)) single_q <= single;
    end
  end

  // DRAIN keeps counting; it only differs from RUN in that run is currently low
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN, DRAIN: begin
        if (at_end) begin
          cnt_nxt   = '0;
          state_nxt = (!run || single_q) ? IDLE : RUN;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = run ? RUN : DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_out <= 1'b0;
      sync      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pulse_out <= counting && in_pulse;
      sync      <= counting && (cnt == '0);
      busy      <= counting;
    end
  end

`ifdef PULSE_SEQ_RECV_GATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) recv_gate <= 1'b0;
    else     recv_gate <= counting && (cnt >= p2_end + act_blank);
  end
`else
  assign recv_gate = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen: directed scenarios plus random traffic against a period-level model.
// Build with PULSE_SEQ_RECV_GATE_EN defined to also exercise cfg_blank/recv_gate.
module tb_pulse_seq_gen;

  localparam int unsigned CNT_W = 32;
`ifdef PULSE_SEQ_RECV_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, run, single, cfg_load;
  logic [CNT_W-1:0] cfg_width, cfg_delay, cfg_period, cfg_blank;
  logic             pulse_out, sync, busy, cfg_err, recv_gate;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: position in period, active/shadow timing, pending load, latched single
  bit     m_in, m_sl, m_pend;
  longint m_k;
  longint a_w, a_d, a_p, a_b, s_w, s_d, s_p, s_b;
  bit     e_pulse, e_sync, e_busy, e_err, e_gate;

  always #5 clk = ~clk;

  pulse_seq_gen #(
    .CNT_W     (CNT_W),
    .WIDTH_DEF (30),
    .DELAY_DEF (200),
    .PERIOD_DEF(200000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .single    (single),
    .cfg_load  (cfg_load),
    .cfg_width (cfg_width),
    .cfg_delay (cfg_delay),
    .cfg_period(cfg_period),
`ifdef PULSE_SEQ_RECV_GATE_EN
    .cfg_blank (cfg_blank),
`endif
    .pulse_out (pulse_out),
    .sync      (sync),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .recv_gate (recv_gate)
  );

  function automatic logic [4:0] obs();
    return {pulse_out, sync, busy, cfg_err, recv_gate};
  endfunction

  function automatic logic [4:0] expv();
    return {e_pulse, e_sync, e_busy, e_err, e_gate};
  endfunction

  function automatic void model_reset();
    m_in = 0; m_sl = 0; m_pend = 0; m_k = 0;
    a_w = 30; a_d = 200; a_p = 200000; a_b = 0;
    s_w = 30; s_d = 200; s_p = 200000; s_b = 0;
    {e_pulse, e_sync, e_busy, e_err, e_gate} = '0;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  function automatic void model_edge();
    bit     bnd, ok;
    longint need;
    e_pulse = m_in && ((m_k < a_w) || (m_k >= a_w + a_d && m_k < 3 * a_w + a_d));
    e_sync  = m_in && (m_k == 0);
    e_busy  = m_in;
    e_gate  = GATE && m_in && (m_k >= 3 * a_w + a_d + a_b);
    need    = 3 * longint'(cfg_width) + longint'(cfg_delay) + 1 + (GATE ? longint'(cfg_blank) : 0);
    ok      = (cfg_width != 0) && (need <= longint'(cfg_period));
    e_err   = cfg_load && !ok;
    bnd     = m_in && (m_k == a_p - 1);
    if ((!m_in || bnd) && m_pend) begin
      a_w = s_w; a_d = s_d; a_p = s_p; a_b = s_b; m_pend = 0;
    end
    if (cfg_load && ok) begin
      s_w = cfg_width; s_d = cfg_delay; s_p = cfg_period; s_b = GATE ? longint'(cfg_blank) : 0;
      m_pend = 1;
    end
    if (m_in && m_k == 0) m_sl = single;
    if (!m_in) begin
      if (run) begin m_in = 1; m_k = 0; end
    end else if (bnd) begin
      m_k = 0;
      if (!run || m_sl) m_in = 0;
    end else begin
      m_k++;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int unsigned w, input int unsigned d, input int unsigned p,
                         input int unsigned b);
    cfg_width = w; cfg_delay = d; cfg_period = p; cfg_blank = b;
  endtask

  task automatic do_reset();
    run = 0; single = 0; cfg_load = 0; rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; run = 0; single = 0; cfg_load = 0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (obs() !== 5'b0) $display("FAIL reset_outputs got %b want 00000", obs()); else n_pass++;
    rst = 0;
    repeat (3) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL reset_idle got %b want %b", obs(), expv()); else n_pass++;
    end
  endtask

  task automatic test_default();
    int highs = 0, syncs = 0;
    run = 1;
    repeat (320) begin
      tick();
      highs += int'(pulse_out); syncs += int'(sync);
      n_total++;
      if (obs() !== expv()) $display("FAIL default k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 90) $display("FAIL default_high_count got %0d want 90", highs); else n_pass++;
    n_total++;
    if (syncs != 1) $display("FAIL default_sync_count got %0d want 1", syncs); else n_pass++;
    do_reset();
  endtask

  task automatic test_small();
    int highs = 0, syncs = 0, gates = 0;
    set_cfg(3, 5, 30, 2); cfg_load = 1;
    tick();
    n_total++;
    if (obs() !== expv()) $display("FAIL small_load got %b want %b", obs(), expv()); else n_pass++;
    cfg_load = 0;
    repeat (2) tick();
    run = 1;
    repeat (61) begin
      tick();
      highs += int'(pulse_out); syncs += int'(sync); gates += int'(recv_gate);
      n_total++;
      if (obs() !== expv()) $display("FAIL small k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 18) $display("FAIL small_high_count got %0d want 18", highs); else n_pass++;
    n_total++;
    if (syncs != 2) $display("FAIL small_sync_count got %0d want 2", syncs); else n_pass++;
    n_total++;
    if (gates != (GATE ? 28 : 0)) $display("FAIL small_gate_count got %0d want %0d", gates, GATE ? 28 : 0);
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 60 && m_k != 10; i++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL drain_wait got %b want %b", obs(), expv()); else n_pass++;
    end
    run = 0;
    repeat (30) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL drain k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL drain_idle busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    int lows = 0;
    single = 1; run = 1;
    tick();
    repeat (34) begin
      tick();
      lows += int'(!busy);
      n_total++;
      if (obs() !== expv()) $display("FAIL single k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (lows != 1) $display("FAIL single_busy_gap got %0d want 1", lows); else n_pass++;
    run = 0; single = 0;
    repeat (35) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL single_stop got %b want %b", obs(), expv()); else n_pass++;
    end
  endtask

  task automatic test_bad_cfg();
    run = 1;
    repeat (5) tick();
    set_cfg(10, 5, 30, 0); cfg_load = 1;
    tick();
    cfg_load = 0;
    n_total++;
    if (cfg_err !== 1'b1) $display("FAIL bad_cfg_err got %b want 1", cfg_err); else n_pass++;
    n_total++;
    if (obs() !== expv()) $display("FAIL bad_cfg got %b want %b", obs(), expv()); else n_pass++;
    repeat (40) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL bad_cfg_after k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
  endtask

  task automatic test_midload();
    int highs = 0;
    for (int i = 0; i < 60 && m_k != 12; i++) tick();
    set_cfg(4, 5, 30, 2); cfg_load = 1;
    tick();
    cfg_load = 0;
    repeat (70) begin
      tick();
      highs += int'(pulse_out);
      n_total++;
      if (obs() !== expv()) $display("FAIL midload k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 25) $display("FAIL midload_high_count got %0d want 25", highs); else n_pass++;
  endtask

  task automatic test_boundary_load();
    int highs = 0, syncs = 0;
    for (int i = 0; i < 60 && m_k != 15; i++) tick();
    set_cfg(2, 4, 20, 2); cfg_load = 1;
    tick();
    cfg_load = 0;
    for (int i = 0; i < 60 && m_k != 29; i++) tick();
    set_cfg(3, 5, 30, 2); cfg_load = 1;
    tick();
    cfg_load = 0;
    repeat (55) begin
      tick();
      highs += int'(pulse_out); syncs += int'(sync);
      n_total++;
      if (obs() !== expv()) $display("FAIL bnd_load k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 18) $display("FAIL bnd_load_high_count got %0d want 18", highs); else n_pass++;
    n_total++;
    if (syncs != 3) $display("FAIL bnd_load_sync_count got %0d want 3", syncs); else n_pass++;
  endtask

  task automatic test_toggle();
    int highs = 0, syncs = 0;
    for (int i = 0; i < 60 && m_k != 5; i++) tick();
    run = 0;
    repeat (43) begin
      if (m_k == 8) run = 1;
      tick();
      highs += int'(pulse_out); syncs += int'(sync);
      n_total++;
      if (obs() !== expv()) $display("FAIL toggle k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 15) $display("FAIL toggle_high_count got %0d want 15", highs); else n_pass++;
    n_total++;
    if (syncs != 1) $display("FAIL toggle_sync_count got %0d want 1", syncs); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int highs = 0;
    for (int i = 0; i < 60 && m_k != 1; i++) tick();
    tick();
    n_total++;
    if (obs() !== expv()) $display("FAIL rst_mid_pre got %b want %b", obs(), expv()); else n_pass++;
    #2 rst = 1;
    #1;
    n_total++;
    if (pulse_out !== 1'b0) $display("FAIL rst_mid_async got %b want 0", pulse_out); else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (35) begin
      tick();
      highs += int'(pulse_out);
      n_total++;
      if (obs() !== expv()) $display("FAIL rst_default k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
    n_total++;
    if (highs != 30) $display("FAIL rst_default_width got %0d want 30", highs); else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    int unsigned w, d, b;
    int          p;
    set_cfg(2, 3, 15, 1); cfg_load = 1;
    tick();
    cfg_load = 0;
    repeat (3000) begin
      cfg_load = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        w = $urandom_range(0, 4);
        d = $urandom_range(0, 6);
        b = GATE ? $urandom_range(0, 3) : 0;
        p = int'(3 * w + d + b + 1 + $urandom_range(0, 10)) - int'($urandom_range(0, 3));
        if (p < 1) p = 1;
        set_cfg(w, d, p, b);
        cfg_load = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) run = !run;
      single = ($urandom_range(0, 3) == 0);
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL random k=%0d got %b want %b", m_k, obs(), expv()); else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_small();
    test_drain();
    test_single();
    test_bad_cfg();
    test_midload();
    test_boundary_load();
    test_toggle();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_seq_gen.md
Name: pulse_seq_gen

Overview:
- Parametrised two-pulse (spin-echo style) sequence generator, clocked from the PLL output domain.
- Emits a pulse of width W, then after a gap D a second pulse of width 2W, repeating every P cycles.
- W, D and P are runtime-loadable through a shadow register and take effect on a period boundary.
- Supports continuous and single-shot modes, with a one-cycle sync strobe per period for scope triggering and receiver logic.

Parameters:
- CNT_W, 32, width of the period counter and all timing fields.
- WIDTH_DEF, 30, reset value of W (cycles).
- DELAY_DEF, 200, reset value of D (cycles).
- PERIOD_DEF, 200000, reset value of P (cycles per period).

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; start or continue sequencing.
- single  in  1  sampled at period start; 1 means run one period then stop.
- cfg_load  in  1  one-cycle strobe; capture cfg_width, cfg_delay and cfg_period.
- cfg_width  in  CNT_W  new W.
- cfg_delay  in  CNT_W  new D.
- cfg_period  in  CNT_W  new P.
- pulse_out  out  1  pulse train.
- sync  out  1  one-cycle strobe at the start of each period.
- busy  out  1  high while a period is in progress.
- cfg_err  out  1  one-cycle strobe; the last load was rejected.
- recv_gate  out  1  receiver window (see Optional Feature).

Behaviour:
- Reset (async, active-high): all outputs 0, counter 0, FSM IDLE, active and shadow config = defaults, no pending load.
- FSM states:
  - IDLE: run=1 moves to RUN with counter=0.
  - RUN: counter counts 0..P-1 and wraps to 0.
  - DRAIN: entered when run falls mid-period; finishes the current period, then goes to IDLE.
- Period boundary is counter==P-1. At the boundary:
  - if run=0 or single-shot was latched, go to IDLE;
  - otherwise wrap.
- single is latched on entry to each period (counter==0 cycle).
- Pulse windows, in counter values k:
  - pulse 1: [0, W)
  - pulse 2: [W+D, 3W+D)
- All outputs are registered: each output in cycle t reflects the counter in cycle t-1, so latency is exactly 1.
- sync is high for one cycle per period, aligned with pulse_out's first cycle.
- busy is 1 from the first cycle of pulse_out through the cycle after the last count of the period.
- Arithmetic is unsigned CNT_W. Validity rule: W≥1 and 3W+D+1 ≤ P, evaluated without overflow (CNT_W+2-bit intermediate).
- cfg_load handling:
  - Invalid values: load rejected, active and shadow config unchanged, cfg_err=1 for one cycle (1 cycle after the strobe).
  - Valid values: written to shadow, pending flag set.
  - Pending shadow is copied to active in IDLE immediately, or at the next period boundary while running.
  - A second valid load before the boundary overwrites the first (last wins).
- Boundary cases:
  - cfg_load coincident with the boundary cycle: the old shadow applies now; the new value is applied at the following boundary.
  - run toggling 1→0→1 inside one period: DRAIN returns to RUN with no break in the period.
  - rst mid-pulse: pulse_out drops asynchronously.

Optional Feature:
- Macro: PULSE_SEQ_RECV_GATE_EN.
- Defined: adds a runtime field cfg_blank (CNT_W, default 0, loaded and applied with the other fields). recv_gate is high for k in [3W+D+blank, P), with the same 1-cycle latency.
  - Validity becomes 3W+D+blank+1 ≤ P.
- Undefined: recv_gate tied 0, cfg_blank port absent, no extra logic.

Decomposition:
- Shared package pulse_seq_pkg:
  - FSM state typedef (IDLE, RUN, DRAIN);
  - CNT_W default;
  - config struct typedef (width, delay, period, blank).
- One sub-module, pulse_seq_cfg: shadow/active registers, validity check, pending flag and apply-on-boundary. Its handshake with the top is apply strobe in, cfg_err out.

Test Plan:
- Reset defaults, run=1 for one period → pulse_out high for counts 0–29 and 230–289; sync exactly once; next sync 200000 cycles later.
- Load W=3, D=5, P=30 in IDLE, then run=1 → pulse_out high at k=0–2 and 8–13, low elsewhere, period 30 cycles.
- Same config, single=1 → one period only, then busy=0 and IDLE.
- run=0 at k=10 → period completes to k=29, no further pulses.
- Load W=10, D=5, P=30 → cfg_err pulse 1 cycle after the strobe; previous W=3 timing continues unchanged.
- Load W=4 mid-period at k=12 (P=30) → current period keeps W=3; next period pulses at k=0–3 and 9–16.
- Assert rst at k=1 with pulse_out high → pulse_out 0 in the same cycle; config returns to defaults.
- With PULSE_SEQ_RECV_GATE_EN, blank=2 (W=3, D=5, P=30) → recv_gate high for k=16–29.
